// File: rtl/gate_stim_sequencer.sv
// Gate-block stimulus sequencer: walks a/b/c through all eight input vectors and
// compacts the returned {i,m,l,e} responses into a 16-bit MISR signature.
module gate_stim_sequencer #(
    parameter int unsigned DWELL    = 1,
    parameter logic [15:0] SIG_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        a,
    output logic        b,
    output logic        c,
    input  logic [3:0]  resp,
    output logic        busy,
    output logic        done,
    output logic [2:0]  vec_idx,
    output logic [15:0] signature,
    output logic        sig_valid
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t      state, next_state;
    logic [7:0]  dwell_cnt, dwell_cnt_nxt;
    logic [2:0]  vec_idx_nxt, abc_nxt;
    logic [15:0] signature_nxt;
    logic        busy_nxt, done_nxt, sig_valid_nxt;
    logic        feedback;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1
    assign feedback = signature[15] ^ signature[13] ^ signature[12] ^ signature[10];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            vec_idx   <= '0;
            signature <= SIG_INIT;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
        end else begin
            state       <= next_state;
            dwell_cnt   <= dwell_cnt_nxt;
            vec_idx     <= vec_idx_nxt;
            signature   <= signature_nxt;
            sig_valid   <= sig_valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            {a, b, c}   <= abc_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !abort) next_state = DRIVE;
            end
            DRIVE: begin
                if (abort)                        next_state = IDLE;
                else if (dwell_cnt == DWELL_LAST) next_state = SAMPLE;
            end
            SAMPLE: begin
                if (abort)                 next_state = IDLE;
                else if (vec_idx == 3'd7)  next_state = DONE;
                else                       next_state = DRIVE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so that every port comes straight off a flop
    always_comb begin
        dwell_cnt_nxt = dwell_cnt;
        vec_idx_nxt   = vec_idx;
        signature_nxt = signature;
        sig_valid_nxt = sig_valid;
        case (state)
            IDLE: begin
                if (next_state == DRIVE) begin
                    dwell_cnt_nxt = '0;
                    vec_idx_nxt   = '0;
                    signature_nxt = SIG_INIT;
                    sig_valid_nxt = 1'b0;
                end
            end
            DRIVE: begin
                if (next_state == DRIVE) dwell_cnt_nxt = dwell_cnt + 8'd1;
            end
            SAMPLE: begin
                if (!abort) begin
                    signature_nxt = {signature[14:0], feedback} ^ {12'h000, resp};
                    if (next_state == DRIVE) begin
                        vec_idx_nxt   = vec_idx + 3'd1;
                        dwell_cnt_nxt = '0;
                    end
                end
            end
            default: begin
            end
        endcase
        if (abort)               sig_valid_nxt = 1'b0;
        if (next_state == DONE)  sig_valid_nxt = 1'b1;
        busy_nxt = (next_state == DRIVE) || (next_state == SAMPLE);
        done_nxt = (next_state == DONE);
        abc_nxt  = busy_nxt ? vec_idx_nxt : 3'd0;
    end

endmodule
